// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: word type, MEM-stage FSM states and link-register width.
package cpu_types_pkg;
    localparam int WORD_W  = 32;
    localparam int REG_AW  = 5;
    localparam int LINK_AW = WORD_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memstate_t;
endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the word address of the last LL and is
// cleared by SC completion, own store to that word, or a coherence invalidate.
module ll_sc_link
    import cpu_types_pkg::*;
#(
    parameter int AW = LINK_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_set,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr,
    input  logic          i_inv,
    input  logic [AW-1:0] i_inv_addr,
    input  logic [AW-1:0] i_chk_addr,
    output logic          o_match
);
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic          w_inv_hit_set;
    logic          w_inv_hit;

    assign w_inv_hit_set = i_inv & (i_inv_addr == i_set_addr);
    assign w_inv_hit     = i_inv & (i_inv_addr == r_addr);

    // An invalidate racing the LL fill to the same word leaves the link cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_set) begin
            r_valid <= ~w_inv_hit_set;
            r_addr  <= i_set_addr;
        end else if (i_clr | w_inv_hit) begin
            r_valid <= 1'b0;
        end
    end

    assign o_match = r_valid & (r_addr == i_chk_addr);
endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the dcache handshake for LW/SW/LL/SC, owns the LL/SC link,
// stalls upstream until the access completes and registers the MEM/WB outputs.
module memory_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_aluout,
    input  logic [WORD_W-1:0] in_storedat,
    input  logic              in_dREN,
    input  logic              in_dWEN,
    input  logic              in_datomic,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic              in_jal,
    input  logic [REG_AW-1:0] in_wsel,
    input  logic [WORD_W-1:0] in_pc4,
    input  logic              in_halt,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              dhit,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              mem_stall,
    output logic              mem_timeout,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_halt,
    output logic [REG_AW-1:0] wb_wsel,
    output logic [WORD_W-1:0] wb_wdat
);
    localparam int LAW = WORD_W - 2;
    localparam int CW  = $clog2(WAIT_MAX + 1);

    memstate_t         r_state;
    memstate_t         w_state_nxt;
    logic [CW-1:0]     r_wait_cnt;
    logic              r_timeout;

    logic              w_live;
    logic              w_mem;
    logic              w_sc;
    logic              w_ll;
    logic              w_sw;
    logic              w_link_match;
    logic              w_sc_fail;
    logic              w_req;
    logic              w_done;
    logic [LAW-1:0]    w_waddr;
    logic [WORD_W-1:0] w_wdat;
    logic              w_unused_snoop_lo;

    assign w_waddr           = in_aluout[WORD_W-1:2];
    assign w_unused_snoop_lo = ^ccsnoopaddr[1:0];

    // Flush only squashes an instruction that has not yet started its access.
    assign w_live    = in_valid & ~wb_halt & ~(flush & (r_state == IDLE));
    assign w_mem     = w_live & (in_dREN | in_dWEN);
    assign w_sc      = w_mem & in_datomic & in_dWEN;
    assign w_ll      = w_mem & in_datomic & in_dREN & ~in_dWEN;
    assign w_sw      = w_mem & ~in_datomic & in_dWEN;
    assign w_sc_fail = w_sc & ~w_link_match;
    assign w_req     = w_mem & ~w_sc_fail;
    assign w_done    = w_live & (~w_req | dhit);

    // Reset gates the request combinationally so it drops before the next edge.
    assign dmemREN     = w_req & in_dREN & ~RST;
    assign dmemWEN     = w_req & in_dWEN & ~RST;
    assign dmemaddr    = (w_req & ~RST) ? {w_waddr, 2'b00} : '0;
    assign dmemstore   = (w_req & in_dWEN & ~RST) ? in_storedat : '0;
    assign mem_stall   = w_req & ~dhit & ~RST;
    assign mem_timeout = r_timeout;

    ll_sc_link #(.AW(LAW)) u_link (
        .CLK        (CLK),
        .RST        (RST),
        .i_set      (w_ll & dhit),
        .i_set_addr (w_waddr),
        .i_clr      ((w_sc & w_done) | (w_sw & dhit & w_link_match)),
        .i_inv      (ccinv),
        .i_inv_addr (ccsnoopaddr[WORD_W-1:2]),
        .i_chk_addr (w_waddr),
        .o_match    (w_link_match)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req & ~dhit) w_state_nxt = ACCESS;
            ACCESS:  if (~w_req | dhit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Diagnostic wait counter: saturates, pulses once, never aborts the access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if ((r_state == ACCESS) && (w_state_nxt == ACCESS)) begin
                if (r_wait_cnt != CW'(WAIT_MAX))   r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt == CW'(WAIT_MAX-1)) r_timeout  <= 1'b1;
            end else if (w_state_nxt == IDLE) begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_wdat = in_aluout;
        if (in_jal)
            w_wdat = in_pc4;
        else if (in_MemtoReg)
            w_wdat = (in_datomic & in_dWEN) ? {{(WORD_W-1){1'b0}}, ~w_sc_fail} : dmemload;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_halt     <= 1'b0;
            wb_wsel     <= '0;
            wb_wdat     <= '0;
        end else if (w_done) begin
            wb_valid    <= 1'b1;
            wb_RegWrite <= in_RegWrite;
            wb_halt     <= wb_halt | in_halt;
            wb_wsel     <= in_wsel;
            wb_wdat     <= w_wdat;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage with a transaction-level memory/link model.
module tb_memory_stage;
    localparam int WAIT_MAX = 255;
    localparam int K_ALU = 0, K_JAL = 1, K_LW = 2, K_SW = 3, K_LL = 4, K_SC = 5, K_HALT = 6;

    logic        CLK = 1'b0, RST = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [31:0] in_aluout = '0, in_storedat = '0, in_pc4 = '0, dmemload = '0, ccsnoopaddr = '0;
    logic        in_dREN = 1'b0, in_dWEN = 1'b0, in_datomic = 1'b0, in_RegWrite = 1'b0;
    logic        in_MemtoReg = 1'b0, in_jal = 1'b0, in_halt = 1'b0, dhit = 1'b0, ccinv = 1'b0;
    logic [4:0]  in_wsel = '0;
    logic        dmemREN, dmemWEN, mem_stall, mem_timeout, wb_valid, wb_RegWrite, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_wdat;
    logic [4:0]  wb_wsel;

    memory_stage #(.WORD_W(32), .REG_AW(5), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_aluout(in_aluout),
        .in_storedat(in_storedat), .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_datomic(in_datomic),
        .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_jal(in_jal), .in_wsel(in_wsel),
        .in_pc4(in_pc4), .in_halt(in_halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .mem_stall(mem_stall), .mem_timeout(mem_timeout),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_halt(wb_halt), .wb_wsel(wb_wsel),
        .wb_wdat(wb_wdat)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic rw; logic [4:0] wsel; logic [31:0] wdat; logic halt; } exp_t;
    exp_t        sbq[$];
    int          n_vec = 0, n_err = 0;
    logic [31:0] mem [logic [29:0]];
    bit          lnk_v = 1'b0, halted = 1'b0;
    logic [29:0] lnk_a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return {2'b00, wa} ^ 32'hA5A5_0000;
    endfunction

    // Monitor: every writeback must match the oldest expected result.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && wb_valid) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL wb_unexpected: got writeback wsel=%0d wdat=%h, expected none", wb_wsel, wb_wdat);
            end else begin
                e = sbq.pop_front();
                chk("wb_RegWrite", {31'd0, wb_RegWrite}, {31'd0, e.rw});
                chk("wb_wsel", {27'd0, wb_wsel}, {27'd0, e.wsel});
                chk("wb_wdat", wb_wdat, e.wdat);
                chk("wb_halt", {31'd0, wb_halt}, {31'd0, e.halt});
            end
        end
    end

    // One instruction through MEM. lat = cycles without dhit; fmode 1 = flush before
    // the access starts, 2 = flush while the access is outstanding.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] sdat,
                         input int lat, input bit inv_hit, input int fmode);
        exp_t e; logic [29:0] wa; bit rd, wr, req, sc_ok, squash, fin; int pulses, pcyc, c;
        wa     = addr[31:2];
        rd     = (kind == K_LW) || (kind == K_LL);
        wr     = (kind == K_SW) || (kind == K_SC);
        sc_ok  = lnk_v && (lnk_a == wa);
        squash = halted || (fmode == 1);
        req    = !squash && (rd || (wr && !(kind == K_SC && !sc_ok)));
        @(posedge CLK); #1;
        in_valid = 1'b1; in_aluout = addr; in_storedat = sdat; in_dREN = rd; in_dWEN = wr;
        in_datomic  = (kind == K_LL) || (kind == K_SC);
        in_RegWrite = !((kind == K_SW) || (kind == K_HALT));
        in_MemtoReg = rd || (kind == K_SC);
        in_jal = (kind == K_JAL); in_halt = (kind == K_HALT);
        in_wsel = 5'($urandom); in_pc4 = $urandom;
        e.rw = in_RegWrite; e.wsel = in_wsel; e.halt = halted || (kind == K_HALT);
        e.wdat = (kind == K_JAL) ? in_pc4 : rd ? mem_rd(wa) : (kind == K_SC) ? {31'd0, sc_ok} : addr;
        if (!squash) sbq.push_back(e);
        pulses = 0; pcyc = -1; c = 0; fin = 1'b0;
        while (!fin) begin
            dhit = req && (c == lat);
            dmemload = (dhit && rd) ? mem_rd(wa) : $urandom;
            ccinv = inv_hit && dhit;
            ccsnoopaddr = {wa, 2'($urandom)};
            flush = (fmode == 1 && c == 0) || (fmode == 2 && c > 0);
            #1;
            chk("dmemREN", {31'd0, dmemREN}, {31'd0, req && rd});
            chk("dmemWEN", {31'd0, dmemWEN}, {31'd0, req && wr});
            chk("mem_stall", {31'd0, mem_stall}, {31'd0, req && (c < lat)});
            if (req) chk("dmemaddr", dmemaddr, {wa, 2'b00});
            if (req && wr) chk("dmemstore", dmemstore, sdat);
            if (mem_timeout) begin pulses++; pcyc = c; end
            fin = !req || (c == lat);
            @(posedge CLK); #1;
            c++;
        end
        in_valid = 1'b0; dhit = 1'b0; ccinv = 1'b0; flush = 1'b0;
        in_dREN = 1'b0; in_dWEN = 1'b0; in_datomic = 1'b0; in_halt = 1'b0;
        if (lat <= WAIT_MAX - 5) chk("timeout_none", pulses, 0);
        if (lat >= WAIT_MAX + 3) begin
            chk("timeout_pulses", pulses, 1);
            chk("timeout_pos", {31'd0, (pcyc >= WAIT_MAX) && (pcyc <= WAIT_MAX + 2)}, 32'd1);
        end
        if (!squash) begin
            if ((kind == K_SW) || (kind == K_SC && sc_ok)) mem[wa] = sdat;
            if (kind == K_LL) begin lnk_v = !inv_hit; lnk_a = wa; end
            if (kind == K_SC) lnk_v = 1'b0;
            if (kind == K_SW && lnk_a == wa) lnk_v = 1'b0;
            if (kind == K_HALT) halted = 1'b1;
        end
    endtask

    task automatic idle_inv(input logic [31:0] a);
        @(posedge CLK); #1;
        ccinv = 1'b1; ccsnoopaddr = a;
        #1 chk("idle_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge CLK); #1;
        ccinv = 1'b0;
        if (lnk_v && lnk_a == a[31:2]) lnk_v = 1'b0;
    endtask

    function automatic logic [31:0] pool_addr();
        logic [31:0] p;
        case ($urandom_range(3))
            0: p = 32'h100;
            1: p = 32'h200;
            2: p = 32'h300;
            default: p = 32'h304;
        endcase
        return p | 32'($urandom_range(3));
    endfunction

    initial begin : main
        int k, lat, r, fm; bit inv;
        // Reset state, with a live load presented during reset.
        in_valid = 1'b1; in_dREN = 1'b1; in_aluout = 32'h100;
        #12;
        chk("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
        chk("rst_dmemaddr", dmemaddr, 32'd0);
        chk("rst_dmemstore", dmemstore, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("rst_wb", {27'd0, wb_valid, wb_RegWrite, wb_halt, 2'b00}, 32'd0);
        chk("rst_wdat", wb_wdat, 32'd0);
        in_valid = 1'b0; in_dREN = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;

        mem[30'h40] = 32'hDEADBEEF;
        issue(K_LW, 32'h100, 0, 3, 0, 0);
        issue(K_SW, 32'h200, 32'h1234, 0, 0, 0);
        issue(K_LL, 32'h300, 0, 1, 0, 0);
        issue(K_SC, 32'h300, 7, 0, 0, 0);
        issue(K_SC, 32'h300, 7, 0, 0, 0);
        issue(K_LL, 32'h300, 0, 0, 0, 0);
        idle_inv(32'h300);
        issue(K_SC, 32'h300, 9, 0, 0, 0);
        issue(K_LL, 32'h304, 0, 2, 1, 0);
        issue(K_SC, 32'h304, 5, 0, 0, 0);
        issue(K_LL, 32'h200, 0, 0, 0, 0);
        issue(K_SW, 32'h200, 32'h55, 1, 0, 0);
        issue(K_SC, 32'h200, 6, 0, 0, 0);

        // Reset while a load waits for dhit.
        issue(K_LL, 32'h300, 0, 0, 0, 0);
        @(posedge CLK); #1;
        in_valid = 1'b1; in_aluout = 32'h100; in_dREN = 1'b1; in_MemtoReg = 1'b1; in_RegWrite = 1'b1;
        @(posedge CLK); #1;
        chk("pre_rst_REN", {31'd0, dmemREN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_acc_REN", {31'd0, dmemREN}, 32'd0);
        chk("rst_acc_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_acc_wbvalid", {31'd0, wb_valid}, 32'd0);
        @(posedge CLK); #1;
        in_valid = 1'b0; in_dREN = 1'b0; RST = 1'b0; lnk_v = 1'b0;
        issue(K_SC, 32'h300, 3, 0, 0, 0);

        issue(K_LW, 32'h100, 0, 300, 0, 0);
        issue(K_ALU, 32'h1111, 0, 0, 0, 1);
        issue(K_LW, 32'h200, 0, 2, 0, 2);

        for (int i = 0; i < 200; i++) begin
            k   = $urandom_range(5);
            lat = $urandom_range(4);
            inv = (k == K_LL) && ($urandom_range(3) == 0);
            r   = $urandom_range(9);
            fm  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            issue(k, pool_addr(), $urandom, lat, inv, fm);
            if ($urandom_range(9) == 0) idle_inv(pool_addr());
        end

        issue(K_HALT, 32'h4444, 0, 0, 0, 0);
        issue(K_LW, 32'h100, 0, 1, 0, 0);
        issue(K_ALU, 32'h5555, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1 chk("halt_sticky", {31'd0, wb_halt}, 32'd1);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
